seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Parametrised sequential shift-add multiplier with its control FSM and datapath in one block; replaces the fixed-width repeated-addition multiplier controller.
- Accepts two WIDTH-bit operands on a start pulse and returns a 2*WIDTH-bit product with a one-cycle done pulse.
- Supports unsigned and two's-complement modes.
- Terminates early once the remaining multiplier bits are zero, so latency depends on the data.

Parameters:
- WIDTH, 8, operand width in bits (legal values 2 to 32).
- SIGNED_EN, 1, when 0 the signed_mode input is ignored and the block is unsigned-only.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = operands are two's complement; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle pulse while in DONE.
- product  output  2*WIDTH  registered result; holds its value until the next completion.

Behaviour:
- Reset: state = IDLE; busy, done, product, internal accumulator, registers and counter all 0. Applies from any state, including mid-CALC; the partial result is discarded.
- FSM states: IDLE, CALC, DONE. Encoding is constants in the package.
- IDLE, start=1 at edge:
  - sgn = signed_mode & SIGNED_EN.
  - ma = |a| and mb = |b|, each WIDTH-bit unsigned. The magnitude of the most-negative value, e.g. -128, is 128 and fits.
  - neg = sgn & (a[MSB] ^ b[MSB]).
  - acc = 0, cnt = 0; go to CALC.
- IDLE, start=0: remain in IDLE.
- CALC, each cycle:
  - if mb[0], acc += ma zero-extended to 2*WIDTH;
  - ma <<= 1 (2*WIDTH-bit register), mb >>= 1, cnt++.
  - Exit to DONE when the next mb == 0 or cnt reaches WIDTH-1.
- CALC cycle count n: n = position of highest set bit of |b| plus 1. n = 1 when b = 0. Maximum n = WIDTH.
- DONE, one cycle:
  - done = 1.
  - product is loaded at the CALC->DONE edge: neg ? -acc : acc, two's complement, 2*WIDTH bits.
  - Unconditionally return to IDLE.
- Latency: start sampled at edge 0 gives CALC during cycles 1..n and done high during cycle n+1.
- Back-to-back: start can be accepted again on the cycle after DONE. Minimum issue interval is n+2 cycles.
- start while busy: ignored, with no effect on operands or state. Operand inputs may change freely after the start edge.
- busy = (state != IDLE). done never overlaps IDLE.
- Arithmetic:
  - acc never overflows 2*WIDTH bits.
  - The signed result range is exact, including (-2^(W-1))^2.
  - A zero product with neg=1 yields 0.

Decomposition:
- Package seq_mult_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2;
  - a constant function for the counter width, clog2(WIDTH).
- One natural sub-module, seq_mult_ctrl: the FSM only.
  - Inputs: start, mb_zero_next, cnt_last.
  - Outputs: ld_ops, step, ld_prod, busy, done.
- Datapath (ma, mb, acc, cnt, sign/negate logic) stays in seq_multiplier.

Test Plan:
- WIDTH=8, unsigned: a=13, b=11, start at edge 0 -> 4 CALC cycles, done in cycle 5, product=16'd143, busy high during cycles 1-5.
- Signed: a=8'hFD (-3), b=8'h05 -> n=3, product=16'hFFF1 (-15). Then a=8'h80, b=8'h80 -> n=8, product=16'h4000.
- Unsigned: a=255, b=255 -> n=8, product=16'hFE01. Signed: a=8'hFF, b=8'hFF -> n=1 (|b|=1), product=16'h0001.
- b=0, a=200 -> n=1, done in cycle 2, product=0. Signed a=8'h80, b=0 -> product=0, not -0 garbage.
- start held high continuously with a=7, b=6 and operands changed mid-CALC:
  - done in cycle 4, product=42;
  - the next operation starts the cycle after DONE with the operands present then;
  - no start is accepted while busy.
- rst asserted in cycle 3 of a b=8'hFF operation:
  - next cycle state IDLE, busy=0, done=0, product=0;
  - a subsequent 3*4 completes with product=12.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared FSM state encoding and the width helper used by the
// sequential shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceil(log2(v)), never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: request/response bundle of the sequential multiplier.
//   start, signed_mode, a, b : request, sampled by the block in IDLE
//   busy, done, product      : status and registered result
interface seq_multiplier_if #(parameter int WIDTH = 8);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (output start, signed_mode, a, b,
                    input  busy, done, product);
    modport slave  (input  start, signed_mode, a, b,
                    output busy, done, product);
endinterface

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: IDLE -> CALC -> DONE control FSM of the shift-add multiplier.
//   start        : request, only honoured in IDLE
//   mb_zero_next : multiplier register becomes zero after this step
//   cnt_last     : this is the final possible step
//   ld_ops       : capture operands, clear accumulator and counter
//   step         : perform one shift-add step
//   ld_prod      : register the final (sign-corrected) product
//   busy, done   : status outputs
module seq_mult_ctrl
    import seq_mult_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic mb_zero_next,
    input  logic cnt_last,
    output logic ld_ops,
    output logic step,
    output logic ld_prod,
    output logic busy,
    output logic done
);

    state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_ops    = 1'b0;
        step      = 1'b0;
        ld_prod   = 1'b0;
        busy      = (state != ST_IDLE);
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    ld_ops    = 1'b1;
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                step = 1'b1;
                // Early exit as soon as no set multiplier bits remain.
                if (mb_zero_next || cnt_last) begin
                    ld_prod   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-add multiplier, unsigned or two's complement.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of seq_multiplier_if (start/signed_mode/a/b in,
//              busy/done/product out)
// Operates on magnitudes and negates the final sum when the operand signs
// differ; stops as soon as the remaining multiplier bits are all zero.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    seq_multiplier_if.slave  bus
);

    localparam int   CW  = clog2(WIDTH);
    localparam logic SEN = (SIGNED_EN != 0);

    logic [2*WIDTH-1:0] ma, acc, acc_nxt, prod_nxt;
    logic [WIDTH-1:0]   mb, a_mag, b_mag;
    logic [CW-1:0]      cnt;
    logic               neg, sgn;
    logic               ld_ops, step, ld_prod, mb_zero_next, cnt_last;

    seq_mult_ctrl u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .start        (bus.start),
        .mb_zero_next (mb_zero_next),
        .cnt_last     (cnt_last),
        .ld_ops       (ld_ops),
        .step         (step),
        .ld_prod      (ld_prod),
        .busy         (bus.busy),
        .done         (bus.done)
    );

    always_comb begin
        sgn = bus.signed_mode & SEN;
        // WIDTH-bit magnitude: the most-negative value maps to 2^(WIDTH-1),
        // which still fits as an unsigned number.
        a_mag = (sgn && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
        b_mag = (sgn && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
        acc_nxt      = mb[0] ? (acc + ma) : acc;
        prod_nxt     = neg ? (~acc_nxt + (2*WIDTH)'(1)) : acc_nxt;
        mb_zero_next = ((mb >> 1) == '0);
        cnt_last     = (cnt == CW'(WIDTH-1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ma          <= '0;
            mb          <= '0;
            acc         <= '0;
            cnt         <= '0;
            neg         <= 1'b0;
            bus.product <= '0;
        end else begin
            if (ld_ops) begin
                ma  <= {{WIDTH{1'b0}}, a_mag};
                mb  <= b_mag;
                acc <= '0;
                cnt <= '0;
                neg <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            end
            if (step) begin
                acc <= acc_nxt;
                ma  <= ma << 1;
                mb  <= mb >> 1;
                cnt <= cnt + CW'(1);
            end
            // Product picks up the final add of the last CALC step directly.
            if (ld_prod) bus.product <= prod_nxt;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_multiplier_if #(.WIDTH(8)) bus ();

    seq_multiplier #(.WIDTH(8), .SIGNED_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.done) begin
            check("busy_with_done", {31'd0, bus.busy}, 32'd1);
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("product", {16'd0, bus.product}, {16'd0, e.prod});
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // One operation: start for a single edge, then scramble the inputs and
    // measure how many cycles busy stays high (n CALC + 1 DONE).
    task automatic do_op(input logic sm, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input int n);
        int bcnt;
        @(negedge clk);
        bus.start = 1'b1; bus.signed_mode = sm; bus.a = a; bus.b = b;
        q.push_back('{exp, cyc + n + 1});
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.signed_mode = 1'($urandom);
        bcnt = 0;
        while (bus.busy && bcnt < 40) begin
            bcnt++;
            @(negedge clk);
        end
        check("busy_cycles", bcnt, n + 1);
        check("product_hold", {16'd0, bus.product}, {16'd0, exp});
    endtask

    initial begin
        int x, guard;
        bus.start = 1'b0; bus.signed_mode = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_product", {16'd0, bus.product}, 32'd0);

        do_op(1'b0, 8'd13,  8'd11,  16'd143,   4);
        do_op(1'b1, 8'hFD,  8'h05,  16'hFFF1,  3);
        do_op(1'b1, 8'h05,  8'hFD,  16'hFFF1,  2);
        do_op(1'b0, 8'hFD,  8'h05,  16'h04F1,  3);
        do_op(1'b1, 8'h80,  8'h80,  16'h4000,  8);
        do_op(1'b0, 8'hFF,  8'hFF,  16'hFE01,  8);
        do_op(1'b1, 8'hFF,  8'hFF,  16'h0001,  1);
        do_op(1'b0, 8'd200, 8'd0,   16'h0000,  1);
        do_op(1'b1, 8'h80,  8'h00,  16'h0000,  1);

        // start held high: 7*6 (n=3) then, back to back, 3*5 (n=3) taken from
        // the operands present during the IDLE cycle after DONE.
        @(negedge clk);
        x = cyc;
        bus.start = 1'b1; bus.signed_mode = 1'b0; bus.a = 8'd7; bus.b = 8'd6;
        q.push_back('{16'd42, x + 4});
        q.push_back('{16'd15, x + 9});
        @(negedge clk);
        @(negedge clk);
        bus.a = 8'd3; bus.b = 8'd5;
        guard = 0;
        while (cyc < x + 9 && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        check("held_start_reach", cyc, x + 9);
        bus.start = 1'b0;
        guard = 0;
        while (bus.busy && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        check("held_start_idle", {31'd0, bus.busy}, 32'd0);

        // Reset during cycle 3 of a b=FF operation discards it.
        @(negedge clk);
        bus.start = 1'b1; bus.signed_mode = 1'b0; bus.a = 8'h11; bus.b = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check("midrst_product", {16'd0, bus.product}, 32'd0);
        rst = 1'b0;
        do_op(1'b0, 8'd3, 8'd4, 16'd12, 3);

        repeat (3) @(negedge clk);
        check("queue_empty", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
